// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer.
// master = requester/consumer side, slave = the sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [AMT_W-1:0] op_amt;
    logic             op_la;
    logic             op_lr;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_y;
    logic             res_c;

    modport master (
        output start_valid, op_a, op_amt, op_la, op_lr, res_ready,
        input  start_ready, res_valid, res_y, res_c
    );

    modport slave (
        input  start_valid, op_a, op_amt, op_la, op_lr, res_ready,
        output start_ready, res_valid, res_y, res_c
    );
endinterface

// File: rtl/shift_sequencer.sv
// Iterates an external single-step 4-bit shifter op_amt times per request.
// Define SHIFT_SEQ_STICKY_C_EN to make res_c the OR of every bit shifted out.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    shift_sequencer_if.slave bus,
    output logic [WIDTH-1:0] sh_a,
    output logic             sh_la,
    output logic             sh_lr,
    input  logic [WIDTH-1:0] sh_y,
    input  logic             sh_c,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             la_q, la_d;
    logic             lr_q, lr_d;
    logic             carry_q, carry_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            la_q    <= 1'b0;
            lr_q    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            la_q    <= la_d;
            lr_q    <= lr_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        la_d    = la_q;
        lr_d    = lr_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    work_d  = bus.op_a;
                    cnt_d   = bus.op_amt;
                    la_d    = bus.op_la;
                    lr_d    = bus.op_lr;
                    carry_d = 1'b0;
                    state_d = (bus.op_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = sh_y;
`ifdef SHIFT_SEQ_STICKY_C_EN
                carry_d = carry_q | sh_c;
`else
                carry_d = sh_c;
`endif
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shifter inputs come straight from registers: no start/ready path reaches sh_*.
    assign sh_a  = work_q;
    assign sh_la = la_q;
    assign sh_lr = lr_q;

    assign bus.start_ready = (state_q == IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.res_y       = work_q;
    assign bus.res_c       = carry_q;
    assign busy            = (state_q == SHIFT) || (state_q == DONE);
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller that sits directly upstream and downstream of the 4-bit single-step combinational shifter in the ALU datapath. Accepts an operand, shift amount and shift mode over a valid/ready handshake, then iterates the shifter once per clock until the requested amount is reached. Presents the final value and carry over a second valid/ready handshake. The shifter itself stays external; this block drives its `A/LA/LR` inputs and registers its `Y/C` outputs.

## Interface
- `WIDTH`, 4, data width; must match the shifter (only 4 is supported)
- `AMT_W`, 3, shift-amount width; amounts 0..7
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start_valid` in 1: request present
- `start_ready` out 1: block can accept a request (high only in IDLE)
- `op_a` in WIDTH: operand
- `op_amt` in AMT_W: number of single-bit shifts
- `op_la` in 1: 0 = logical, 1 = arithmetic (ignored when `op_lr`=0)
- `op_lr` in 1: 0 = left, 1 = right
- `sh_a` out WIDTH: to shifter `A`
- `sh_la` out 1: to shifter `LA`
- `sh_lr` out 1: to shifter `LR`
- `sh_y` in WIDTH: from shifter `Y`
- `sh_c` in 1: from shifter `C`
- `res_valid` out 1: result present
- `res_ready` in 1: consumer takes result
- `res_y` out WIDTH: shifted value
- `res_c` out 1: carry (see Configuration)
- `busy` out 1: high in SHIFT or DONE

## Operation
- Registers:
  - `work` (WIDTH)
  - `cnt` (AMT_W)
  - `la_q`, `lr_q`
  - `carry`
  - `state`
- Outputs `sh_a` = `work`, `sh_la` = `la_q`, `sh_lr` = `lr_q`, driven directly from registers at all times.
- States:
  - IDLE:
    - `start_ready`=1.
    - On `start_valid`: `work`←`op_a`, `cnt`←`op_amt`, `la_q`←`op_la`, `lr_q`←`op_lr`, `carry`←0.
    - Next state is DONE if `op_amt`==0, else SHIFT.
  - SHIFT:
    - Every cycle: `work`←`sh_y`, `carry`←carry update, `cnt`←`cnt`−1.
    - When `cnt`==1 at the edge, next state is DONE.
  - DONE:
    - `res_valid`=1, `res_y`=`work`, `res_c`=`carry`.
    - On `res_ready`, next state is IDLE.
- Shift amounts ≥ WIDTH are legal and are simply iterated:
  - Left shift result is 0000.
  - Logical right shift result is 0000.
  - Arithmetic right shift result is 0000 or 1111, depending on `op_a[3]`.
- `start_valid` outside IDLE is ignored; the request is not latched.
- `rst` in any state:
  - Next state is IDLE.
  - All registers clear to 0.
  - Any in-flight operation is discarded with no result produced.

## Timing
- Reset values:
  - `start_ready`=1, `res_valid`=0, `busy`=0
  - `res_y`=0000, `res_c`=0
  - `sh_a`=0000, `sh_la`=0, `sh_lr`=0
- Accept happens on the edge where `start_valid` && `start_ready`.
- Latency for amount N ≥ 1: `res_valid` rises after the Nth edge following the accept edge.
- Latency for N=0: `res_valid` is high in the cycle immediately after the accept edge.
- Result hand-off happens on the edge where `res_valid` && `res_ready`. The next accept is possible no earlier than the following edge, so there is one IDLE cycle minimum between operations.
- While `res_valid` && !`res_ready`, `res_y` and `res_c` are held stable indefinitely.
- Combinational path is `work` → external shifter → `work`; there is no combinational path from `start_*` or `res_ready` to any `sh_*` output.

## Configuration
- `SHIFT_SEQ_STICKY_C_EN` defined:
  - Carry update is `carry`←`carry` | `sh_c`.
  - `res_c`=1 if any 1 was shifted out over the whole operation.
- Not defined:
  - Carry update is `carry`←`sh_c`.
  - `res_c` is the last bit shifted out.
- Both builds: `res_c`=0 for N=0.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` for 2 cycles during SHIFT of a 5-step operation.
  - Required: next cycle shows IDLE, `start_ready`=1, `res_valid`=0, `busy`=0, `sh_a`=0000. No result is ever produced for the aborted operation.
- **Left by 1:**
  - Stimulus: `op_a`=1011, amt=1, `op_lr`=0, `res_ready`=1.
  - Required: `res_valid` after 1 edge; `res_y`=0110, `res_c`=1.
- **Arithmetic right by 3:**
  - Stimulus: `op_a`=1001, amt=3, `op_lr`=1, `op_la`=1.
  - Required:
    - `sh_a` sequence is 1001, 1100, 1110.
    - `res_y`=1111.
    - `res_c`=0 without the macro; `res_c`=1 with `SHIFT_SEQ_STICKY_C_EN`.
- **Logical right by 5 (amount > width):**
  - Stimulus: `op_a`=1000, amt=5, `op_lr`=1, `op_la`=0.
  - Required: `res_y`=0000 after 5 edges; `res_c`=0 without the macro, 1 with it.
- **Zero amount with backpressure:**
  - Stimulus: `op_a`=0101, amt=0, `res_ready`=0 for 3 cycles. Pulse `start_valid` with `op_a`=1111 during that window.
  - Required:
    - `res_valid` is high in the cycle after accept.
    - `res_y`=0101, `res_c`=0, stable for all 3 cycles.
    - The second request is ignored (`start_ready`=0).
- **Back-to-back:**
  - Stimulus: hold `start_valid`=1 and `res_ready`=1 with alternating requests.
  - Required:
    - Exactly one IDLE cycle between each result hand-off and the next accept.
    - Each result matches the single-step reference model iterated N times.
